// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: M-stage data memory bus sequencer with flush cancel and M2 load capture
module dmem_access_ctrl #(
    parameter bit ADDR_MAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic        mem_wenM,
    input  logic [1:0]  mem_sizeM,
    input  logic [31:0] data_addrM,
    input  logic [31:0] writedataM,
    input  logic [3:0]  mem_write_selectM,
    input  logic        addr_errM,
    input  logic        flushM,
    input  logic        pipe_advance,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] mem_rdataM2,
    output logic        rdata_validM2,
    output logic        stall_mem
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic        cancel;
    logic        req_v;
    logic        kill;
    logic        done_ok;
    logic [31:0] mapped_addr;

    assign req_v       = mem_enM & ~addr_errM & ~flushM;
    assign kill        = cancel | flushM;
    assign done_ok     = data_data_ok & ((state == ADDR & data_addr_ok) | state == DATA);
    assign mapped_addr = (ADDR_MAP_EN && data_addrM[31:30] == 2'b10) ? {3'b000, data_addrM[28:0]} : data_addrM;

    // outputs are gated by reset so the bus and pipeline see quiet values during reset
    assign data_req      = rst & (state == ADDR);
    assign stall_mem     = rst & ((state == IDLE & req_v) | state == ADDR | state == DATA);
    assign rdata_validM2 = rst & (state == DONE) & pipe_advance & ~data_wr;

    // one outstanding transaction: capture in IDLE, hold fields until completion, cancelled ones skip DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cancel      <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= 2'b00;
            data_addr   <= 32'h0;
            data_wstrb  <= 4'h0;
            data_wdata  <= 32'h0;
            mem_rdataM2 <= 32'h0;
        end else begin
            if (state == IDLE && req_v) begin
                data_wr    <= mem_wenM;
                data_size  <= mem_sizeM;
                data_addr  <= mapped_addr;
                data_wstrb <= mem_wenM ? mem_write_selectM : 4'h0;
                data_wdata <= writedataM;
                state      <= ADDR;
            end
            if (state == ADDR || state == DATA) cancel <= kill;
            if (state == ADDR && data_addr_ok && !data_data_ok) state <= DATA;
            if (done_ok) begin
                state  <= kill ? IDLE : DONE;
                cancel <= 1'b0;
                if (!kill && !data_wr) mem_rdataM2 <= data_rdata;
            end
            if (state == DONE && pipe_advance) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench for the data memory access controller
module tb_dmem_access_ctrl;
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_enM = 1'b0, mem_wenM = 1'b0, addr_errM = 1'b0, flushM = 1'b0, pipe_advance = 1'b0;
    logic [1:0]  mem_sizeM = 2'b00;
    logic [31:0] data_addrM = 32'h0, writedataM = 32'h0, data_rdata = 32'h0;
    logic [3:0]  mem_write_selectM = 4'h0;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic        data_req, data_wr, rdata_validM2, stall_mem;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, mem_rdataM2;
    logic [3:0]  data_wstrb;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];
    int          n_chk = 0, n_pass = 0, stall_cnt = 0, mode = 0;
    req_t        cur;
    logic        cur_ld = 1'b0;
    logic [31:0] cur_rd = 32'h0, last_rd = 32'h0;
    logic [31:0] bases[5] = '{32'h8000_0000, 32'hA000_0000, 32'h0000_0000, 32'hC000_0000, 32'hE000_0000};

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_MAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_enM(mem_enM), .mem_wenM(mem_wenM), .mem_sizeM(mem_sizeM),
        .data_addrM(data_addrM), .writedataM(writedataM), .mem_write_selectM(mem_write_selectM),
        .addr_errM(addr_errM), .flushM(flushM), .pipe_advance(pipe_advance),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_rdataM2(mem_rdataM2),
        .rdata_validM2(rdata_validM2), .stall_mem(stall_mem)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        logic [2:0] seg;
        seg = a[31:29];
        return (seg == 3'd4 || seg == 3'd5) ? {3'b000, a[28:0]} : a;
    endfunction

    // one clock: sample at negedge, then drive just after the rising edge
    task automatic cyc();
        @(negedge clk);
        if (stall_mem) stall_cnt++;
        if (mode == 1) begin
            chk("hold_req", data_req, 1);
            chk("hold_addr", data_addr, cur.addr);
            chk("hold_wdata", data_wdata, cur.wdata);
        end
        if (mode == 2) begin
            chk("no_reissue", data_req, 0);
            chk("done_stall", stall_mem, 0);
            if (cur_ld) chk("rd_hold", mem_rdataM2, cur_rd);
        end
        @(posedge clk);
        #1;
    endtask

    // fl: 0 none, 1 flush in first ADDR wait cycle (al>=1), 2 flush in first DATA cycle (dl>=2)
    task automatic xact(input logic wen, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int al, input int dl, input int hl,
                        input logic [31:0] rd, input int fl);
        req_t e;
        logic kill;
        kill = (fl != 0);
        e = '{map_addr(addr), wen, size, wen ? strb : 4'h0, wdata};
        cur = e;
        exp_req_q.push_back(e);
        if (!wen && !kill) exp_rd_q.push_back(rd);
        stall_cnt = 0;
        mem_enM = 1'b1; mem_wenM = wen; mem_sizeM = size; data_addrM = addr;
        writedataM = wdata; mem_write_selectM = strb;
        cyc();
        mode = 1;
        for (int i = 0; i < al; i++) begin
            if (fl == 1 && i == 0) begin flushM = 1'b1; mem_enM = 1'b0; end
            data_addrM = $urandom; writedataM = $urandom;
            cyc();
            flushM = 1'b0;
        end
        mode = 0;
        data_addr_ok = 1'b1;
        if (dl == 0) begin data_data_ok = 1'b1; data_rdata = rd; end
        cyc();
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
        if (dl > 0) begin
            for (int i = 1; i < dl; i++) begin
                if (fl == 2 && i == 1) begin flushM = 1'b1; mem_enM = 1'b0; end
                cyc();
                flushM = 1'b0;
            end
            data_data_ok = 1'b1; data_rdata = rd;
            cyc();
            data_data_ok = 1'b0; data_rdata = $urandom;
        end
        if (!wen && !kill) last_rd = rd;
        cur_ld = !wen && !kill;
        cur_rd = rd;
        mode = kill ? 0 : 2;
        for (int i = 0; i < hl; i++) cyc();
        mode = 0;
        pipe_advance = 1'b1;
        cyc();
        pipe_advance = 1'b0; mem_enM = 1'b0; mem_wenM = 1'b0;
        chk("stall_cycles", stall_cnt, 2 + al + dl);
        chk("rdata_keep", mem_rdataM2, last_rd);
    endtask

    // scoreboard: bus requests checked at address acceptance, loads checked on the M2 valid pulse
    always @(negedge clk) begin
        req_t e;
        if (rst && data_req && data_addr_ok) begin
            chk("req_expected", 32'(exp_req_q.size() > 0), 1);
            if (exp_req_q.size() > 0) begin
                e = exp_req_q.pop_front();
                chk("req_addr", data_addr, e.addr);
                chk("req_wr", data_wr, e.wr);
                chk("req_size", data_size, e.size);
                chk("req_wstrb", data_wstrb, e.wstrb);
                chk("req_wdata", data_wdata, e.wdata);
            end
        end
        if (rdata_validM2) begin
            chk("rd_expected", 32'(exp_rd_q.size() > 0), 1);
            if (exp_rd_q.size() > 0) chk("rd_data", mem_rdataM2, exp_rd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", data_req, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_size", data_size, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wstrb", data_wstrb, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_rdata", mem_rdataM2, 0);
        chk("rst_valid", rdata_validM2, 0);
        chk("rst_stall", stall_mem, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        xact(1'b0, 2'b10, 32'h8000_1004, 32'h0, 4'hF, 0, 3, 0, 32'hDEAD_BEEF, 0);
        xact(1'b1, 2'b00, 32'hA000_0003, 32'h1111_1111, 4'b1000, 0, 1, 0, 32'h0, 0);
        xact(1'b1, 2'b01, 32'hBFC0_0012, 32'hABCD_0000, 4'b1100, 4, 2, 3, 32'h0, 0);
        xact(1'b0, 2'b10, 32'h0040_0010, 32'h0, 4'h0, 0, 0, 2, 32'h0BAD_F00D, 0);
        xact(1'b0, 2'b10, 32'hC000_0020, 32'h0, 4'h0, 1, 1, 1, 32'h7654_3210, 0);
        xact(1'b0, 2'b10, 32'h8000_2000, 32'h0, 4'h0, 0, 3, 0, 32'h1234_5678, 2);
        xact(1'b0, 2'b10, 32'h8000_2004, 32'h0, 4'h0, 2, 0, 0, 32'h8765_4321, 1);
        for (int k = 0; k < 2; k++) begin
            mem_enM = 1'b1; mem_wenM = 1'b0; data_addrM = 32'h8000_3000;
            addr_errM = (k == 0); flushM = (k == 1);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("sup_req", data_req, 0);
                chk("sup_stall", stall_mem, 0);
                @(posedge clk);
                #1;
            end
            mem_enM = 1'b0; addr_errM = 1'b0; flushM = 1'b0;
        end
        for (int n = 0; n < 8; n++) begin
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 bases[$urandom_range(0, 4)] | ($urandom & 32'h1FFF_FFFC), $urandom, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 0);
        end
        mem_enM = 1'b1; mem_wenM = 1'b1; mem_sizeM = 2'b10; data_addrM = 32'h8000_0040;
        writedataM = 32'hCAFE_F00D; mem_write_selectM = 4'hF;
        cyc();
        @(negedge clk);
        chk("pre_rst_req", data_req, 1);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_enM = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("mid_rst_req", data_req, 0);
        chk("mid_rst_wr", data_wr, 0);
        chk("mid_rst_addr", data_addr, 0);
        chk("mid_rst_wdata", data_wdata, 0);
        chk("mid_rst_wstrb", data_wstrb, 0);
        chk("mid_rst_stall", stall_mem, 0);
        @(posedge clk);
        #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("stale_ok_rdata", mem_rdataM2, 0);
        chk("stale_ok_valid", rdata_validM2, 0);
        chk("stale_ok_req", data_req, 0);
        @(posedge clk);
        #1;
        last_rd = 32'h0;
        xact(1'b0, 2'b10, 32'h8000_0100, 32'h0, 4'h0, 1, 2, 1, 32'hFEED_FACE, 0);
        chk("req_q_empty", exp_req_q.size(), 0);
        chk("rd_q_empty", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter ADDR_MAP_EN, default 1: 1 = fold kseg0/kseg1 virtual addresses to physical; 0 = pass the address through unchanged.
REQ-002 clk  in  1  single clock; every register updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-low reset: registers take reset values on the rising edge of clk while rst=0.
REQ-004 mem_enM  in  1  M-stage instruction performs a load or store.
REQ-005 mem_wenM  in  1  access is a store.
REQ-006 mem_sizeM  in  2  00 byte, 01 half, 10 word.
REQ-007 data_addrM  in  32  access virtual address.
REQ-008 writedataM  in  32  store data, already byte-lane aligned.
REQ-009 mem_write_selectM  in  4  store byte strobes.
REQ-010 addr_errM  in  1  address exception on either issue slot; the access is suppressed.
REQ-011 flushM  in  1  M-stage flush (exception or eret).
REQ-012 pipe_advance  in  1  M to M2 pipeline register advances this cycle.
REQ-013 data_req/data_wr  out  1/1  bus request / write flag.
REQ-014 data_size  out  2;  data_addr  out  32;  data_wstrb  out  4;  data_wdata  out  32  bus request fields.
REQ-015 data_addr_ok/data_data_ok  in  1/1  bus address accept / data return.
REQ-016 data_rdata  in  32  bus read data.
REQ-017 mem_rdataM2  out  32  captured raw load word delivered to M2.
REQ-018 rdata_validM2  out  1  single-cycle pulse: mem_rdataM2 belongs to the load now entering M2.
REQ-019 stall_mem  out  1  freezes M and all earlier stages.

Function
REQ-020 FSM states: IDLE, ADDR, DATA, DONE; reset state is IDLE.
REQ-021 Request valid: req_v = mem_enM & ~addr_errM & ~flushM.
REQ-022 IDLE with req_v: capture addr (mapped), size, wr, wstrb (forced to 0000 for loads), wdata; go to ADDR.
REQ-023 data_req=1 only in ADDR; all bus fields come from the captured registers and stay stable until data_addr_ok.
REQ-024 ADDR with data_addr_ok: go to DATA; if data_data_ok is also 1 in that cycle, go straight to DONE.
REQ-025 DATA with data_data_ok: go to DONE; for a load, mem_rdataM2 <= data_rdata.
REQ-026 DONE with pipe_advance: go to IDLE; rdata_validM2=1 in that cycle if the access was a load.
REQ-027 DONE without pipe_advance: hold the state; mem_rdataM2 holds its value.
REQ-028 stall_mem = (IDLE & req_v) | ADDR | DATA; DONE does not stall.
REQ-029 Best-case load latency: IDLE (request seen) -> ADDR (addr_ok and data_ok) -> DONE, i.e. 2 stalled cycles.
REQ-030 No request is issued in DONE, so the completed instruction is never re-issued.
REQ-031 Address map with ADDR_MAP_EN=1: addr[31:29] of 100 or 101 becomes {000, addr[28:0]}; all other addresses pass unchanged.
REQ-032 flushM in IDLE: no request.
REQ-033 flushM in ADDR: data_req is not withdrawn; set the cancel flag.
REQ-034 flushM in DATA: set the cancel flag.
REQ-035 A cancelled transaction completes on the bus, does not update mem_rdataM2, then goes to IDLE (not DONE) with stall_mem=1 until it ends.
REQ-036 A cancelled store is already accepted by the bus and is not undone; the upstream exception logic keeps flushed stores out of M.
REQ-037 Only one transaction is outstanding at a time; a new request waits for data_ok of the previous one.

Reset
REQ-038 While rst=0: state=IDLE; data_req=0, data_wr=0; data_size, data_addr, data_wstrb, data_wdata = 0; mem_rdataM2=0; rdata_validM2=0; stall_mem=0; cancel flag=0.
REQ-039 Reset mid-transaction: abandon to IDLE; the bus is reset in the same cycle, and stale data_ok is not tracked.

Verification
REQ-040 Load word at 0x8000_1004, addr_ok same cycle, data_ok 3 cycles later with 0xDEADBEEF -> data_addr=0x0000_1004, wstrb=0000, mem_rdataM2=0xDEADBEEF, stall_mem high 5 cycles, rdata_validM2 pulses on advance.
REQ-041 Store sb at 0xA000_0003, wstrb=1000, wdata=0x11111111 -> data_wr=1, data_addr=0x0000_0003, data_wstrb=1000; mem_rdataM2 unchanged.
REQ-042 addr_errM=1 with mem_enM=1 -> data_req never asserted, stall_mem=0.
REQ-043 flushM pulse while in DATA on a load, data_ok returns 0x12345678 -> mem_rdataM2 keeps its old value, FSM goes to IDLE, rdata_validM2 stays 0.
REQ-044 data_addr_ok held low 4 cycles -> data_addr and data_wdata stable throughout; pipe_advance=0 in DONE holds the state and does not issue a second request.
REQ-045 rst=0 asserted in ADDR -> next edge: all outputs at reset values; a data_ok arriving afterwards is ignored.
